imem_prog: RTL and testbench

Parametrised, run-time-programmable instruction memory for the core's fetch stage. It stores `DEPTH` words of `DATA_W` bits and serves one registered fetch per cycle, with a stall hold. It accepts program writes through a valid/ready loader port. On every reset it fills the whole array with the NOP encoding before it accepts any traffic, so unprogrammed locations always execute as NOP.

---
 rtl/imem_prog.sv | 146 ++++++++++++++
 tb/tb_imem_prog.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_prog.sv
// Programmable instruction memory: NOP-filled on reset, one registered fetch per cycle, loader write port.
// Latency: fetch 1 cycle (request edge to fetch_valid); write visible to the next fetch, same-cycle via bypass.
// Backpressure: prog_ready low during the NOP fill; fetch_stall freezes all fetch outputs.
module imem_prog #(
  parameter int          DATA_W   = 32,
  parameter int          DEPTH    = 64,
  parameter int          PC_W     = 32,
  parameter logic [31:0] NOP_WORD = 32'h0007_8000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [PC_W-1:0]   fetch_addr,
  input  logic              fetch_stall,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_oob,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_err,
  output logic              init_done
);

  localparam int                ADDR_W    = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] NOP       = DATA_W'(NOP_WORD);
  // One extra bit so the range check never wraps at the top of the PC space.
  localparam logic [PC_W:0]     DEPTH_EXT = (PC_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] init_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              run;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_widx;
  logic [DATA_W-1:0] mem_wdat;
  logic              prog_in_range;
  logic              fetch_in_range;
  logic              bypass;
  logic [DATA_W-1:0] rd_word;

  // Full-width range checks: upper address bits are never dropped.
  assign prog_in_range  = {1'b0, prog_addr}  < DEPTH_EXT;
  assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_EXT;

  // A same-address write in the accepting cycle overrides the stored word.
  assign bypass  = run && prog_valid && prog_in_range && (prog_addr == fetch_addr);
  assign rd_word = mem[fetch_addr[ADDR_W-1:0]];

  assign prog_ready = run;
  assign init_done  = run;

  // State register: every reset restarts the NOP fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and single array write port: fill counter in INIT, loader in RUN.
  always_comb begin
    state_d  = state_q;
    run      = 1'b0;
    mem_we   = 1'b0;
    mem_widx = init_cnt;
    mem_wdat = NOP;
    case (state_q)
      S_INIT: begin
        mem_we = 1'b1;
        if (init_cnt == LAST_IDX) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        run = 1'b1;
        if (prog_valid && prog_in_range) begin
          mem_we   = 1'b1;
          mem_widx = prog_addr[ADDR_W-1:0];
          mem_wdat = prog_data;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Fill index, advancing once per INIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt <= '0;
    end else if (state_q == S_INIT) begin
      init_cnt <= init_cnt + 1'b1;
    end
  end

  // Array write; suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_widx] <= mem_wdat;
    end
  end

  // Registered fetch response with stall hold and out-of-range NOP substitution.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_valid <= 1'b0;
      fetch_data  <= NOP;
      fetch_oob   <= 1'b0;
    end else if (run && !fetch_stall) begin
      if (fetch_req) begin
        fetch_valid <= 1'b1;
        fetch_oob   <= !fetch_in_range;
        if (!fetch_in_range) begin
          fetch_data <= NOP;
        end else if (bypass) begin
          fetch_data <= prog_data;
        end else begin
          fetch_data <= rd_word;
        end
      end else begin
        fetch_valid <= 1'b0;
        fetch_oob   <= 1'b0;
      end
    end
  end

  // One-cycle pulse for each out-of-range write that is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      prog_err <= 1'b0;
    end else begin
      prog_err <= run && prog_valid && !prog_in_range;
    end
  end

endmodule

// File: tb/tb_imem_prog.sv
// Bench for imem_prog: default instance and a DEPTH=16/DATA_W=16 instance share one stimulus stream.
// A behavioural model per instance is compared against every output on every falling edge.
// Directed sequences add literal expectations for fill length, bypass, errors, stall and reset.
module tb_imem_prog;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic        fetch_stall;
  logic [31:0] fetch_addr;
  logic        prog_valid;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;

  logic        a_valid, a_oob, a_ready, a_err, a_done;
  logic [31:0] a_data;
  logic        b_valid, b_oob, b_ready, b_err, b_done;
  logic [15:0] b_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imem_prog dut_a (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .fetch_valid(a_valid), .fetch_data(a_data), .fetch_oob(a_oob),
    .prog_valid(prog_valid), .prog_ready(a_ready), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_err(a_err), .init_done(a_done)
  );

  imem_prog #(.DATA_W(16), .DEPTH(16)) dut_b (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .fetch_valid(b_valid), .fetch_data(b_data), .fetch_oob(b_oob),
    .prog_valid(prog_valid), .prog_ready(b_ready), .prog_addr(prog_addr),
    .prog_data(prog_data[15:0]), .prog_err(b_err), .init_done(b_done)
  );

  // ---------------- behavioural model (index 0: instance a, 1: instance b)
  logic [31:0] m_mem [2][64];
  logic [31:0] m_dep [2] = '{32'd64, 32'd16};
  logic [31:0] m_msk [2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};
  int          m_since [2];
  logic        m_valid [2];
  logic        m_oob   [2];
  logic        m_err   [2];
  logic [31:0] m_data  [2];
  bit          m_live = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Edges since reset with rst low; the array is usable once that reaches DEPTH.
  task automatic model_step(input int k);
    logic [31:0] nop;
    logic [31:0] pd;
    logic        wr_in;
    logic        f_oob;
    nop = 32'h0007_8000 & m_msk[k];
    pd  = prog_data & m_msk[k];
    if (rst) begin
      m_since[k] = 0;
      m_valid[k] = 1'b0;
      m_oob[k]   = 1'b0;
      m_err[k]   = 1'b0;
      m_data[k]  = nop;
      for (int i = 0; i < 64; i++) m_mem[k][i] = nop;
    end else if (m_since[k] < int'(m_dep[k])) begin
      m_since[k]++;
      m_err[k] = 1'b0;
    end else begin
      wr_in = prog_valid && (prog_addr < m_dep[k]);
      // Apply the write first, so a same-cycle fetch naturally sees new data.
      if (wr_in) m_mem[k][prog_addr[5:0]] = pd;
      if (!fetch_stall) begin
        if (fetch_req) begin
          f_oob      = fetch_addr >= m_dep[k];
          m_valid[k] = 1'b1;
          m_oob[k]   = f_oob;
          m_data[k]  = f_oob ? nop : m_mem[k][fetch_addr[5:0]];
        end else begin
          m_valid[k] = 1'b0;
          m_oob[k]   = 1'b0;
        end
      end
      m_err[k] = prog_valid && !wr_in;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    if (rst) m_live = 1'b1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_live) begin
      check("a_fetch_valid", 32'(a_valid), 32'(m_valid[0]));
      check("a_fetch_data",  a_data,       m_data[0]);
      check("a_fetch_oob",   32'(a_oob),   32'(m_oob[0]));
      check("a_prog_err",    32'(a_err),   32'(m_err[0]));
      check("a_prog_ready",  32'(a_ready), 32'(m_since[0] >= 64));
      check("a_init_done",   32'(a_done),  32'(m_since[0] >= 64));
      check("b_fetch_valid", 32'(b_valid), 32'(m_valid[1]));
      check("b_fetch_data",  {16'h0, b_data}, m_data[1]);
      check("b_fetch_oob",   32'(b_oob),   32'(m_oob[1]));
      check("b_prog_err",    32'(b_err),   32'(m_err[1]));
      check("b_prog_ready",  32'(b_ready), 32'(m_since[1] >= 16));
      check("b_init_done",   32'(b_done),  32'(m_since[1] >= 16));
    end
  end

  // ---------------- stimulus
  task automatic idle_inputs();
    fetch_req   = 1'b0;
    fetch_stall = 1'b0;
    fetch_addr  = '0;
    prog_valid  = 1'b0;
    prog_addr   = '0;
    prog_data   = '0;
  endtask

  // Cycle 1 is the first cycle with rst low; returns the cycle in which init_done is first high.
  task automatic wait_init(output int a_cyc, output int b_cyc);
    a_cyc = 0;
    b_cyc = 0;
    for (int n = 1; n <= 200 && a_cyc == 0; n++) begin
      @(negedge clk);
      if (b_done && b_cyc == 0) b_cyc = n + 1;
      if (a_done) a_cyc = n + 1;
    end
  endtask

  function automatic logic [31:0] pick_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 7)       return 32'($urandom_range(0, 63));
    else if (r == 7) return 32'($urandom_range(64, 127));
    else if (r == 8) return 32'($urandom);
    else             return 32'h4000_0000 | 32'($urandom_range(0, 63));
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 32'(a_valid), 32'd0);
    check({tag, "_data"},  a_data,       32'h0007_8000);
    check({tag, "_oob"},   32'(a_oob),   32'd0);
    check({tag, "_ready"}, 32'(a_ready), 32'd0);
    check({tag, "_err"},   32'(a_err),   32'd0);
    check({tag, "_done"},  32'(a_done),  32'd0);
    check({tag, "_b_data"}, {16'h0, b_data}, 32'h0000_8000);
  endtask

  initial begin
    int a_cyc;
    int b_cyc;
    rst = 1'b1;
    idle_inputs();

    // Reset held for two edges, then released mid-cycle.
    @(negedge clk);
    @(negedge clk);
    check_reset_values("rst");
    rst = 1'b0;
    wait_init(a_cyc, b_cyc);
    check("init_len_a", 32'(a_cyc), 32'd65);
    check("init_len_b", 32'(b_cyc), 32'd17);

    // Every location reads back as NOP, one cycle after each request.
    for (int i = 0; i <= 64; i++) begin
      if (i < 64) begin
        fetch_req  = 1'b1;
        fetch_addr = 32'(i);
      end else begin
        fetch_req = 1'b0;
      end
      @(negedge clk);
      if (i < 64) begin
        check("sweep_valid", 32'(a_valid), 32'd1);
        check("sweep_data",  a_data,       32'h0007_8000);
      end
    end

    // Program two words and fetch them back to back.
    prog_valid = 1'b1; prog_addr = 32'd1; prog_data = 32'h8008_0001;
    @(negedge clk);
    prog_addr = 32'd2; prog_data = 32'h8210_0001;
    @(negedge clk);
    prog_valid = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'd1;
    @(negedge clk);
    check("rd1", a_data, 32'h8008_0001);
    fetch_addr = 32'd2;
    @(negedge clk);
    check("rd2", a_data, 32'h8210_0001);
    fetch_addr = 32'd3;
    @(negedge clk);
    check("rd3", a_data, 32'h0007_8000);

    // Same-cycle write and fetch of the same address.
    prog_valid = 1'b1; prog_addr = 32'd2; prog_data = 32'hDEAD_BEEF;
    fetch_addr = 32'd2;
    @(negedge clk);
    check("bypass", a_data, 32'hDEAD_BEEF);
    prog_valid = 1'b0; fetch_req = 1'b0;

    // Out-of-range write is dropped with a single-cycle error pulse.
    prog_valid = 1'b1; prog_addr = 32'd64; prog_data = 32'h1111_1111;
    @(negedge clk);
    prog_valid = 1'b0;
    check("err_pulse", 32'(a_err), 32'd1);
    fetch_req = 1'b1; fetch_addr = 32'd0;
    @(negedge clk);
    check("err_clear", 32'(a_err), 32'd0);
    check("no_alias_data", a_data, 32'h0007_8000);
    check("no_alias_oob", 32'(a_oob), 32'd0);
    fetch_addr = 32'd100;
    @(negedge clk);
    check("oob_data", a_data, 32'h0007_8000);
    check("oob_flag", 32'(a_oob), 32'd1);
    fetch_req = 1'b0;
    @(negedge clk);
    check("idle_valid", 32'(a_valid), 32'd0);
    check("idle_oob", 32'(a_oob), 32'd0);

    // Stall freezes the response for its whole duration.
    fetch_req = 1'b1; fetch_addr = 32'd1;
    @(negedge clk);
    check("pre_stall", a_data, 32'h8008_0001);
    fetch_stall = 1'b1; fetch_addr = 32'd2;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall_valid", 32'(a_valid), 32'd1);
      check("stall_data",  a_data,       32'h8008_0001);
    end
    fetch_stall = 1'b0;
    @(negedge clk);
    check("post_stall", a_data, 32'hDEAD_BEEF);
    idle_inputs();

    // Randomised traffic, model-checked every cycle.
    for (int c = 0; c < 3000; c++) begin
      fetch_req   = ($urandom_range(0, 3) != 0);
      fetch_stall = ($urandom_range(0, 3) == 0);
      fetch_addr  = pick_addr();
      prog_valid  = ($urandom_range(0, 1) != 0);
      prog_addr   = ($urandom_range(0, 4) == 0) ? fetch_addr : pick_addr();
      prog_data   = $urandom;
      @(negedge clk);
    end
    idle_inputs();

    // Reset during an active fetch wipes programmed contents.
    prog_valid = 1'b1; prog_addr = 32'd5; prog_data = 32'h1234_5678;
    @(negedge clk);
    prog_valid = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'd5;
    @(negedge clk);
    check("pre_rst_data", a_data, 32'h1234_5678);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("midrst");
    rst = 1'b0;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      check("refill_ready", 32'(a_ready), 32'(n >= 64));
      check("refill_b_done", 32'(b_done), 32'(n >= 16));
      if (n < 64) check("refill_valid", 32'(a_valid), 32'd0);
    end
    @(negedge clk);
    check("refill_fetch_valid", 32'(a_valid), 32'd1);
    check("refill_fetch_data", a_data, 32'h0007_8000);
    idle_inputs();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
